// File: rtl/axi_pkg.sv
// Shared definitions for the single-outstanding AXI-style initiator.
//   axi_init_state_t : controller FSM state encoding
//   RESP_*           : AXI response codes (RESP_DECERR doubles as the local timeout code)
//   addr_aligned()   : true when a byte address is a multiple of the beat size
package axi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWaddr,
        StWresp,
        StRaddr,
        StRdata,
        StDone
    } axi_init_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // bsize is a power of two, so the modulo reduces to a mask test.
    function automatic logic addr_aligned(input logic [63:0] addr, input int unsigned bsize);
        logic [63:0] mask;
        mask = 64'(bsize) - 64'd1;
        return (addr & mask) == 64'd0;
    endfunction

endpackage

// File: rtl/axi_phase_timer.sv
// Saturating phase-wait counter.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : reload the count with zero (takes priority over en)
//   en       : count one cycle
//   expired  : count has reached LIMIT-1; the counter holds there
module axi_phase_timer #(
    parameter int unsigned LIMIT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q;

    assign expired = (cnt_q == CW'(LIMIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/axi_init_ctrl.sv
// Single-outstanding AXI-style initiator with alignment check and per-phase timeout.
//   aclk, reset              : clock, asynchronous active-high reset
//   cmd_*                    : local command (valid/ready, write flag, address, write data)
//   rsp_*                    : one-cycle response pulse with read data, resp code, timeout flag
//   awvalid/awready/wadd     : write-address channel
//   wvalid/wready/datain     : write-data channel
//   bvalid/bready/bresp      : write-response channel
//   arvalid/aready/araddr    : read-address channel
//   rvalid/rready/dataout/rresp : read-data channel
module axi_init_ctrl
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned BSIZE   = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic              aclk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_resp,
    output logic              rsp_timeout,
    output logic              awvalid,
    input  logic              awready,
    output logic [ADDR_W-1:0] wadd,
    output logic              wvalid,
    input  logic              wready,
    output logic [DATA_W-1:0] datain,
    input  logic              bvalid,
    output logic              bready,
    input  logic [1:0]        bresp,
    output logic              arvalid,
    input  logic              aready,
    output logic [ADDR_W-1:0] araddr,
    input  logic              rvalid,
    output logic              rready,
    input  logic [DATA_W-1:0] dataout,
    input  logic [1:0]        rresp
);

    axi_init_state_t   state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        resp_q, resp_d;
    logic              tout_q, tout_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;
    logic bus_phase, phase_expired, phase_tmo, timer_clr, aligned;

    assign aligned = addr_aligned(64'(cmd_addr), BSIZE);

    assign aw_hs  = awvalid_q & awready;
    assign w_hs   = wvalid_q & wready;
    assign b_hs   = (state_q == StWresp) & bvalid;
    assign ar_hs  = (state_q == StRaddr) & aready;
    assign r_hs   = (state_q == StRdata) & rvalid;
    assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

    assign bus_phase = (state_q == StWaddr) || (state_q == StWresp) ||
                       (state_q == StRaddr) || (state_q == StRdata);

    // Any handshake counts as progress, so a phase only times out when it is idle.
    assign phase_tmo = bus_phase & phase_expired & ~any_hs;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        tout_d    = tout_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    rdata_d = '0;
                    resp_d  = RESP_OKAY;
                    tout_d  = 1'b0;
                    if (!aligned) begin
                        state_d = StDone;
                        resp_d  = RESP_SLVERR;
                    end else if (cmd_write) begin
                        state_d   = StWaddr;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d = StRaddr;
                    end
                end
            end
            StWaddr: begin
                if (aw_hs) awvalid_d = 1'b0;
                if (w_hs)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = StWresp;
            end
            StWresp: begin
                if (bvalid) begin
                    resp_d  = bresp;
                    state_d = StDone;
                end
            end
            StRaddr: begin
                if (aready) state_d = StRdata;
            end
            StRdata: begin
                if (rvalid) begin
                    rdata_d = dataout;
                    resp_d  = rresp;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (phase_tmo) begin
            state_d   = StDone;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            rdata_d   = '0;
            resp_d    = RESP_DECERR;
            tout_d    = 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            tout_q    <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            tout_q    <= tout_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
        end
    end

    // Restart the wait budget on every state change and every handshake.
    assign timer_clr = (state_d != state_q) | any_hs;

    axi_phase_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .clk     (aclk),
        .rst     (reset),
        .clr     (timer_clr),
        .en      (bus_phase),
        .expired (phase_expired)
    );

    assign cmd_ready   = (state_q == StIdle);
    assign rsp_valid   = (state_q == StDone);
    assign rsp_rdata   = rsp_valid ? rdata_q : '0;
    assign rsp_resp    = rsp_valid ? resp_q : RESP_OKAY;
    assign rsp_timeout = rsp_valid & tout_q;

    assign awvalid = awvalid_q;
    assign wadd    = awvalid_q ? addr_q : '0;
    assign wvalid  = wvalid_q;
    assign datain  = wvalid_q ? wdata_q : '0;
    assign bready  = (state_q == StWresp);
    assign arvalid = (state_q == StRaddr);
    assign araddr  = arvalid ? addr_q : '0;
    assign rready  = (state_q == StRdata);

endmodule

// File: tb/tb_axi_init_ctrl.sv
// Self-checking bench for axi_init_ctrl: directed cases plus randomized transactions,
// each compared against a cycle-timeline model of the command/response behaviour.
module tb_axi_init_ctrl;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BSIZE   = 4;
    localparam int unsigned TIMEOUT = 32;
    localparam int          T       = int'(TIMEOUT);
    localparam int          BUDGET  = 4 * T + 20;

    logic              aclk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              cmd_ready, rsp_valid, rsp_timeout;
    logic [DATA_W-1:0] rsp_rdata;
    logic [1:0]        rsp_resp;
    logic              awvalid, wvalid, bready, arvalid, rready;
    logic              awready = 1'b0, wready = 1'b0, bvalid = 1'b0, aready = 1'b0, rvalid = 1'b0;
    logic [ADDR_W-1:0] wadd, araddr;
    logic [DATA_W-1:0] datain;
    logic [DATA_W-1:0] dataout = '0;
    logic [1:0]        bresp = '0, rresp = '0;

    always #5 aclk = ~aclk;

    axi_init_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BSIZE  (BSIZE),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .aclk       (aclk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_resp   (rsp_resp),
        .rsp_timeout(rsp_timeout),
        .awvalid    (awvalid),
        .awready    (awready),
        .wadd       (wadd),
        .wvalid     (wvalid),
        .wready     (wready),
        .datain     (datain),
        .bvalid     (bvalid),
        .bready     (bready),
        .bresp      (bresp),
        .arvalid    (arvalid),
        .aready     (aready),
        .araddr     (araddr),
        .rvalid     (rvalid),
        .rready     (rready),
        .dataout    (dataout),
        .rresp      (rresp)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int          rsp_at;
        logic [1:0]  resp;
        bit          tmo;
        logic [31:0] rdata;
        int          aw_cyc, w_cyc, ar_cyc, b_cyc, r_cyc;
    } exp_t;

    // A phase entered at edge 'entry' whose partner waits k cycles finishes at entry+1+k,
    // unless k reaches the timeout budget, in which case it is abandoned at entry+T.
    function automatic void phase_end(input int entry, input int k, output int done_at,
                                      output bit tmo);
        if (k <= T - 1) begin
            done_at = entry + 1 + k;
            tmo     = 1'b0;
        end else begin
            done_at = entry + T;
            tmo     = 1'b1;
        end
    endfunction

    // Edge offsets are relative to the command-accept edge N (= 0).
    function automatic exp_t model(input bit wr, input logic [31:0] addr, input int kaw,
                                   input int kw, input int kb, input int kar, input int kr,
                                   input logic [1:0] br, input logic [1:0] rr,
                                   input logic [31:0] rd);
        exp_t e;
        int   d1, d2, d3, k1, k2, done;
        bit   t1, t2, t3;
        e.resp = 2'b00; e.tmo = 1'b0; e.rdata = 32'd0;
        e.aw_cyc = 0; e.w_cyc = 0; e.ar_cyc = 0; e.b_cyc = 0; e.r_cyc = 0;
        if ((addr % BSIZE) != 0) begin
            e.rsp_at = 1;
            e.resp   = 2'b10;
            return e;
        end
        if (wr) begin
            k1 = (kaw < kw) ? kaw : kw;
            k2 = (kaw < kw) ? kw : kaw;
            phase_end(0, k1, d1, t1);
            if (t1) begin
                e.aw_cyc = T; e.w_cyc = T; done = d1; e.tmo = 1'b1;
            end else begin
                phase_end(d1, k2 - k1 - 1, d2, t2);
                if (!t2) begin
                    e.aw_cyc = kaw + 1; e.w_cyc = kw + 1;
                end else if (kaw < kw) begin
                    e.aw_cyc = kaw + 1; e.w_cyc = d2;
                end else begin
                    e.aw_cyc = d2; e.w_cyc = kw + 1;
                end
                done = d2;
                if (t2) begin
                    e.tmo = 1'b1;
                end else begin
                    phase_end(d2, kb, d3, t3);
                    e.b_cyc = d3 - d2;
                    done    = d3;
                    e.tmo   = t3;
                    e.resp  = br;
                end
            end
        end else begin
            phase_end(0, kar, d1, t1);
            e.ar_cyc = d1;
            done     = d1;
            e.tmo    = t1;
            if (!t1) begin
                phase_end(d1, kr, d2, t2);
                e.r_cyc = d2 - d1;
                done    = d2;
                e.tmo   = t2;
                e.resp  = rr;
                e.rdata = rd;
            end
        end
        if (e.tmo) begin
            e.resp  = 2'b11;
            e.rdata = 32'd0;
        end
        e.rsp_at = done + 1;
        return e;
    endfunction

    // Issues one command and plays the slave; readies/valids appear after the given waits.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int kaw, input int kw, input int kb, input int kar,
                           input int kr, input logic [1:0] br, input logic [1:0] rr,
                           input logic [31:0] rd);
        exp_t e;
        int   aw_seen = 0, w_seen = 0, ar_seen = 0, b_seen = 0, r_seen = 0;
        int   aw_cyc = 0, w_cyc = 0, ar_cyc = 0, b_cyc = 0, r_cyc = 0;
        int   pay_err = 0, busy_err = 0, c = 1;
        bit   got = 1'b0;
        e = model(wr, addr, kaw, kw, kb, kar, kr, br, rr, rd);
        @(negedge aclk);
        check("cmd_ready_before", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
        @(negedge aclk);
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
        while (!got && c <= BUDGET) begin
            if (awvalid) aw_cyc++;
            if (wvalid)  w_cyc++;
            if (arvalid) ar_cyc++;
            if (bready)  b_cyc++;
            if (rready)  r_cyc++;
            if (wadd   !== (awvalid ? addr  : 32'd0)) pay_err++;
            if (datain !== (wvalid  ? wdata : 32'd0)) pay_err++;
            if (araddr !== (arvalid ? addr  : 32'd0)) pay_err++;
            if (cmd_ready) busy_err++;
            if (rsp_valid) begin
                got = 1'b1;
            end else begin
                awready = awvalid && (aw_seen >= kaw); if (awvalid) aw_seen++;
                wready  = wvalid  && (w_seen  >= kw);  if (wvalid)  w_seen++;
                aready  = arvalid && (ar_seen >= kar); if (arvalid) ar_seen++;
                bvalid  = bready  && (b_seen  >= kb);  if (bready)  b_seen++;
                rvalid  = rready  && (r_seen  >= kr);  if (rready)  r_seen++;
                bresp   = bvalid ? br : 2'($urandom);
                rresp   = rvalid ? rr : 2'($urandom);
                dataout = rvalid ? rd : $urandom;
                @(negedge aclk);
                c++;
            end
        end
        check("rsp_seen", 64'(got), 64'd1);
        check("rsp_cycle", 64'(c), 64'(e.rsp_at));
        check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
        check("rsp_timeout", 64'(rsp_timeout), 64'(e.tmo));
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("awvalid_cycles", 64'(aw_cyc), 64'(e.aw_cyc));
        check("wvalid_cycles", 64'(w_cyc), 64'(e.w_cyc));
        check("arvalid_cycles", 64'(ar_cyc), 64'(e.ar_cyc));
        check("bready_cycles", 64'(b_cyc), 64'(e.b_cyc));
        check("rready_cycles", 64'(r_cyc), 64'(e.r_cyc));
        check("bus_payload_errs", 64'(pay_err), 64'd0);
        check("cmd_ready_busy", 64'(busy_err), 64'd0);
        awready = 1'b0; wready = 1'b0; aready = 1'b0; bvalid = 1'b0; rvalid = 1'b0;
        @(negedge aclk);
        check("idle_after_rsp", 64'({cmd_ready, rsp_valid}), 64'b10);
    endtask

    function automatic int pick_delay();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return int'($urandom_range(0, 3));
        if (r < 8) return int'($urandom_range(TIMEOUT - 2, TIMEOUT + 1));
        return int'($urandom_range(0, 10));
    endfunction

    initial begin
        int          pulses;
        logic [31:0] a;

        // Reset state
        @(negedge aclk);
        @(negedge aclk);
        check("reset_ctl", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                                rsp_timeout, rsp_resp}), 64'd0);
        check("reset_bus", 64'(wadd | araddr | datain | rsp_rdata), 64'd0);
        check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
        reset = 1'b0;

        // Zero-wait write, zero-wait-ish read, split write handshakes, misaligned, read timeout
        run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        run_txn(1'b0, 32'h0000_0020, 32'h0, 0, 0, 0, 2, 0, 2'b00, 2'b00, 32'h1234_5678);
        run_txn(1'b1, 32'h0000_0030, 32'hA5A5_0F0F, 0, 3, 1, 0, 0, 2'b01, 2'b00, 32'h0);
        run_txn(1'b1, 32'h0000_0006, 32'h1111_2222, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        run_txn(1'b0, 32'h0000_0044, 32'h0, 0, 0, 0, 1000, 0, 2'b00, 2'b00, 32'h0);
        // Boundary waits: last cycle before the budget runs out, and one past it
        run_txn(1'b0, 32'h0000_0048, 32'h0, 0, 0, 0, T - 1, T - 1, 2'b00, 2'b01, 32'hFEED_0001);
        run_txn(1'b1, 32'h0000_004C, 32'h5, T - 1, 0, T, 0, 0, 2'b10, 2'b00, 32'h0);
        run_txn(1'b1, 32'h0000_0050, 32'h6, 2, 2 + T + 1, 0, 0, 0, 2'b00, 2'b00, 32'h0);

        // Reset while waiting for the write response: no pulse, outputs cleared at once
        @(negedge aclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'hCAFE_F00D;
        awready = 1'b1; wready = 1'b1;
        @(negedge aclk);
        cmd_valid = 1'b0;
        @(negedge aclk);
        awready = 1'b0; wready = 1'b0;
        check("wresp_bready", 64'(bready), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_ctl", 64'({awvalid, wvalid, bready, arvalid, rready, rsp_valid,
                                 rsp_timeout, rsp_resp}), 64'd0);
        check("midrst_bus", 64'(wadd | araddr | datain | rsp_rdata), 64'd0);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge aclk);
        reset = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge aclk);
            if (rsp_valid) pulses++;
        end
        check("midrst_no_rsp", 64'(pulses), 64'd0);
        check("midrst_idle", 64'(cmd_ready), 64'd1);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            run_txn(1'($urandom), a, $urandom, pick_delay(), pick_delay(), pick_delay(),
                    pick_delay(), pick_delay(), 2'($urandom), 2'($urandom_range(0, 1)),
                    $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
